// File: rtl/airbag_squib_driver.sv
// Qualifies the airbag deploy command and drives one fixed-width squib firing pulse, then latches deployed.
// Optional squib continuity monitoring is enabled by defining AIRBAG_CONTINUITY_EN.
module airbag_squib_driver #(
    parameter int ARM_DELAY      = 8,
    parameter int CONFIRM_CYCLES = 4,
    parameter int FIRE_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       airbag_req,
    input  logic       arm_en,
`ifdef AIRBAG_CONTINUITY_EN
    input  logic       squib_ok,
`endif
    output logic       squib_fire,
    output logic       deployed,
    output logic       fault,
    output logic [2:0] state
);

    localparam int MAX_AC  = (ARM_DELAY > CONFIRM_CYCLES) ? ARM_DELAY : CONFIRM_CYCLES;
    localparam int MAX_ALL = (MAX_AC > FIRE_CYCLES) ? MAX_AC : FIRE_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] ARM_LAST  = CW'(ARM_DELAY - 1);
    localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CYCLES);
    localparam logic [CW-1:0] FIRE_LAST = CW'(FIRE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam bit            CONF_ONE  = (CONFIRM_CYCLES == 1);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_ARMED   = 3'd1,
        S_CONFIRM = 3'd2,
        S_FIRE    = 3'd3,
        S_DONE    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          qualify;
    logic          cont_bad;

    assign qualify = airbag_req & arm_en;
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

`ifdef AIRBAG_CONTINUITY_EN
    assign cont_bad = ~squib_ok;
`else
    assign cont_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_inc;
                if (cnt_q == ARM_LAST) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end
            end
            S_ARMED: begin
                if (cont_bad) begin
                    state_d = S_FAULT;
                end else if (qualify) begin
                    if (CONF_ONE) begin
                        state_d = S_FIRE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_CONFIRM;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            S_CONFIRM: begin
                // Continuity loss beats a same-edge confirm; any gap in the request restarts qualification.
                if (cont_bad) begin
                    state_d = S_FAULT;
                end else if (!qualify) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end else if (cnt_inc == CONF_LAST) begin
                    state_d = S_FIRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FIRE: begin
                cnt_d = cnt_inc;
                if (cnt_q == FIRE_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE, S_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            squib_fire <= 1'b0;
            deployed   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            squib_fire <= (state_d == S_FIRE);
            deployed   <= (state_d == S_DONE);
        end
    end

`ifdef AIRBAG_CONTINUITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else begin
            fault <= (state_d == S_FAULT);
        end
    end
`else
    assign fault = 1'b0;
`endif

    assign state = state_q;

endmodule

// File: tb/tb_airbag_squib_driver.sv
// Directed bench for airbag_squib_driver with default parameters (8/4/16).
module tb_airbag_squib_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       airbag_req = 1'b0;
    logic       arm_en = 1'b0;
`ifdef AIRBAG_CONTINUITY_EN
    logic       squib_ok = 1'b1;
`endif
    logic       squib_fire;
    logic       deployed;
    logic       fault;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    airbag_squib_driver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .airbag_req (airbag_req),
        .arm_en     (arm_en),
`ifdef AIRBAG_CONTINUITY_EN
        .squib_ok   (squib_ok),
`endif
        .squib_fire (squib_fire),
        .deployed   (deployed),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset is released 1 time unit after a rising edge, so the next edge is edge 1.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Counts edges with squib_fire high over a fixed window.
    task automatic count_fire(input int window, output int highs);
        highs = 0;
        for (int i = 0; i < window; i++) begin
            step(1);
            if (squib_fire) highs++;
        end
    endtask

    initial begin
        int highs;
        int bad;

        // 1: nominal fire with request held from reset release
        airbag_req = 1'b1;
        arm_en     = 1'b1;
        rst_n      = 1'b0;
        #2;
        check("reset_state", state, 0);
        check("reset_fire", squib_fire, 0);
        check("reset_deployed", deployed, 0);
        check("reset_fault", fault, 0);
        do_reset();
        for (int k = 1; k <= 128; k++) begin
            int es;
            step(1);
            es = (k < 8) ? 0 : (k < 9) ? 1 : (k < 12) ? 2 : (k < 28) ? 3 : 4;
            check($sformatf("nom_state_e%0d", k), state, 16'(es));
            check($sformatf("nom_fire_e%0d", k), squib_fire, (es == 3) ? 16'd1 : 16'd0);
            check($sformatf("nom_deployed_e%0d", k), deployed, (es == 4) ? 16'd1 : 16'd0);
        end

        // 2: glitch rejection
        airbag_req = 1'b0;
        arm_en     = 1'b1;
        do_reset();
        step(8);
        check("glitch_armed", state, 1);
        airbag_req = 1'b1;
        step(3);
        check("glitch_burst1_state", state, 2);
        check("glitch_burst1_fire", squib_fire, 0);
        airbag_req = 1'b0;
        step(1);
        check("glitch_gap_state", state, 1);
        check("glitch_gap_fire", squib_fire, 0);
        airbag_req = 1'b1;
        step(3);
        check("glitch_burst2_e3_state", state, 2);
        check("glitch_burst2_e3_fire", squib_fire, 0);
        step(1);
        check("glitch_burst2_e4_fire", squib_fire, 1);
        check("glitch_burst2_e4_state", state, 3);

        // 3: disarmed, then armed
        airbag_req = 1'b1;
        arm_en     = 1'b0;
        do_reset();
        step(8);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (squib_fire !== 1'b0 || state !== 3'd1) bad++;
        end
        check("disarmed_bad_cycles", 16'(bad), 0);
        arm_en = 1'b1;
        step(3);
        check("arm_e3_fire", squib_fire, 0);
        check("arm_e3_state", state, 2);
        step(1);
        check("arm_e4_fire", squib_fire, 1);

        // 4: no abort, one-shot (fire rose at FIRE cycle 1 above)
        step(2);
        check("abort_cycle3_fire", squib_fire, 1);
        airbag_req = 1'b0;
        arm_en     = 1'b0;
        count_fire(40, highs);
        check("abort_pulse_width", 16'(highs + 3), 16);
        check("abort_done_state", state, 4);
        check("abort_deployed", deployed, 1);
        airbag_req = 1'b1;
        arm_en     = 1'b1;
        count_fire(50, highs);
        check("oneshot_second_pulse", 16'(highs), 0);
        check("oneshot_deployed", deployed, 1);
        check("oneshot_state", state, 4);

        // 5: reset mid-pulse
        do_reset();
        step(12);
        check("midrst_fire_start", squib_fire, 1);
        step(4);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_fire", squib_fire, 0);
        check("midrst_deployed", deployed, 0);
        check("midrst_state", state, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(7);
        check("midrst_blank_e7_state", state, 0);
        check("midrst_blank_e7_fire", squib_fire, 0);
        step(1);
        check("midrst_blank_e8_state", state, 1);

`ifdef AIRBAG_CONTINUITY_EN
        // 6: continuity fault in CONFIRM, then squib_ok loss during FIRE
        squib_ok = 1'b1;
        do_reset();
        step(9);
        check("cont_confirm_state", state, 2);
        squib_ok = 1'b0;
        step(1);
        check("cont_fault_state", state, 5);
        check("cont_fault_flag", fault, 1);
        squib_ok = 1'b1;
        count_fire(30, highs);
        check("cont_fault_no_fire", 16'(highs), 0);
        check("cont_fault_hold", state, 5);
        do_reset();
        step(12);
        check("cont_fire_start", squib_fire, 1);
        squib_ok = 1'b0;
        count_fire(40, highs);
        check("cont_fire_width", 16'(highs + 1), 16);
        check("cont_fire_done", state, 4);
        check("cont_fire_no_fault", fault, 0);
        squib_ok = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
